// File: rtl/preg_freelist.sv
// Physical register free list: circular queue with speculative and committed heads.
// Grants are combinational from registered state; flush rewinds the speculative head to the committed head.
module preg_freelist #(
  parameter int REG_SIZE       = 64,
  parameter int REG_SIZE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_req,
  output logic                      alloc_gnt,
  output logic [REG_SIZE_WIDTH-1:0] alloc_prd,
  input  logic                      commit_valid,
  input  logic                      release_valid,
  input  logic [REG_SIZE_WIDTH-1:0] release_prd,
  input  logic                      flush,
  output logic [REG_SIZE_WIDTH:0]   free_count,
  output logic                      empty,
  output logic                      err
);

  localparam int PW = REG_SIZE_WIDTH + 1;

  logic [REG_SIZE_WIDTH-1:0] r_queue [REG_SIZE];
  logic [PW-1:0]             r_spec_head;
  logic [PW-1:0]             r_commit_head;
  logic [PW-1:0]             r_tail;
  logic                      r_err;

  logic [PW-1:0] w_occupancy;
  logic          w_full;
  logic          w_commit_ok;
  logic          w_commit_bad;
  logic          w_release_ok;
  logic          w_release_bad;
  logic [PW-1:0] w_commit_head_nxt;
  logic [PW-1:0] w_spec_head_nxt;

  // Entries between commit_head and spec_head are allocated but still recoverable by flush.
  assign free_count  = r_tail - r_spec_head;
  assign empty       = (free_count == '0);
  assign alloc_prd   = r_queue[r_spec_head[REG_SIZE_WIDTH-1:0]];
  assign alloc_gnt   = alloc_req & ~empty & ~flush;
  assign err         = r_err;

  assign w_occupancy   = r_tail - r_commit_head;
  assign w_full        = (w_occupancy == PW'(REG_SIZE));
  assign w_commit_ok   = commit_valid && (r_commit_head != r_spec_head);
  assign w_commit_bad  = commit_valid && (r_commit_head == r_spec_head);
  assign w_release_ok  = release_valid && (release_prd != '0) && !w_full;
  assign w_release_bad = release_valid && (release_prd != '0) && w_full;

  assign w_commit_head_nxt = w_commit_ok ? r_commit_head + PW'(1) : r_commit_head;

  always_comb begin
    w_spec_head_nxt = r_spec_head;
    if (flush) begin
      w_spec_head_nxt = w_commit_head_nxt;
    end else if (alloc_gnt) begin
      w_spec_head_nxt = r_spec_head + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= PW'(REG_SIZE / 2);
      r_err         <= 1'b0;
    end else begin
      r_spec_head   <= w_spec_head_nxt;
      r_commit_head <= w_commit_head_nxt;
      if (w_release_ok) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_commit_bad || w_release_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Upper half of the register file starts free; the lower half holds architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        r_queue[i] <= (i < REG_SIZE / 2) ? REG_SIZE_WIDTH'(REG_SIZE / 2 + i) : '0;
      end
    end else if (w_release_ok) begin
      r_queue[r_tail[REG_SIZE_WIDTH-1:0]] <= release_prd;
    end
  end

endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist: scoreboard holds the expected grant order.
module tb_preg_freelist;

  logic       clk;
  logic       reset;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [5:0] alloc_prd;
  logic       commit_valid;
  logic       release_valid;
  logic [5:0] release_prd;
  logic       flush;
  logic [6:0] free_count;
  logic       empty;
  logic       err;

  int         n_checks;
  int         n_errors;
  logic [5:0] sb[$];
  logic [5:0] exp_prd;

  preg_freelist #(.REG_SIZE(64), .REG_SIZE_WIDTH(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_gnt     (alloc_gnt),
    .alloc_prd     (alloc_prd),
    .commit_valid  (commit_valid),
    .release_valid (release_valid),
    .release_prd   (release_prd),
    .flush         (flush),
    .free_count    (free_count),
    .empty         (empty),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; combinational outputs are sampled 2ns later.
  task automatic drive(input logic req, input logic cv, input logic rv, input logic [5:0] prd, input logic fl);
    alloc_req     = req;
    commit_valid  = cv;
    release_valid = rv;
    release_prd   = prd;
    flush         = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 6'd0, 0);
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) sb.push_back(6'(32 + i));
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (free_count !== 7'd32) begin n_errors++; $display("FAIL reset_free_count: got %0d expected 32", free_count); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL reset_empty: got %0b expected 0", empty); end
    n_checks++; if (alloc_prd !== 6'd32) begin n_errors++; $display("FAIL reset_alloc_prd: got %0d expected 32", alloc_prd); end
    n_checks++; if (alloc_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_alloc_gnt: got %0b expected 0", alloc_gnt); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    tick();
  endtask

  task automatic test_alloc_basic();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 6'd0, 0);
      exp_prd = sb.pop_front();
      n_checks++; if (alloc_gnt !== 1'b1) begin n_errors++; $display("FAIL basic_gnt[%0d]: got %0b expected 1", k, alloc_gnt); end
      n_checks++; if (alloc_prd !== exp_prd) begin n_errors++; $display("FAIL basic_prd[%0d]: got %0d expected %0d", k, alloc_prd, exp_prd); end
      n_checks++; if (free_count !== 7'(32 - k)) begin n_errors++; $display("FAIL basic_free_count[%0d]: got %0d expected %0d", k, free_count, 32 - k); end
      tick();
    end
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (free_count !== 7'd29) begin n_errors++; $display("FAIL basic_free_count_end: got %0d expected 29", free_count); end
  endtask

  task automatic test_exhaust_release();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      drive(1, 0, 0, 6'd0, 0);
      exp_prd = sb.pop_front();
      n_checks++; if (alloc_gnt !== 1'b1 || alloc_prd !== exp_prd) begin n_errors++; $display("FAIL exhaust_grant[%0d]: got gnt=%0b prd=%0d expected gnt=1 prd=%0d", k, alloc_gnt, alloc_prd, exp_prd); end
      tick();
    end
    drive(1, 0, 1, 6'd5, 0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL exhaust_empty: got %0b expected 1", empty); end
    n_checks++; if (alloc_gnt !== 1'b0) begin n_errors++; $display("FAIL exhaust_no_bypass_gnt: got %0b expected 0", alloc_gnt); end
    sb.push_back(6'd5);
    tick();
    drive(1, 0, 0, 6'd0, 0);
    exp_prd = sb.pop_front();
    n_checks++; if (alloc_gnt !== 1'b1) begin n_errors++; $display("FAIL exhaust_regrant_gnt: got %0b expected 1", alloc_gnt); end
    n_checks++; if (alloc_prd !== exp_prd) begin n_errors++; $display("FAIL exhaust_regrant_prd: got %0d expected %0d", alloc_prd, exp_prd); end
    n_checks++; if (free_count !== 7'd1) begin n_errors++; $display("FAIL exhaust_free_count: got %0d expected 1", free_count); end
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL exhaust_empty_again: got %0b expected 1", empty); end
  endtask

  task automatic test_commit_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 6'd0, 0);
      exp_prd = sb.pop_front();
      n_checks++; if (alloc_prd !== exp_prd) begin n_errors++; $display("FAIL flush_alloc_prd[%0d]: got %0d expected %0d", k, alloc_prd, exp_prd); end
      tick();
    end
    drive(0, 1, 0, 6'd0, 0);
    tick();
    drive(0, 0, 0, 6'd0, 1);
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (free_count !== 7'd31) begin n_errors++; $display("FAIL flush_free_count: got %0d expected 31", free_count); end
    n_checks++; if (alloc_prd !== 6'd33) begin n_errors++; $display("FAIL flush_alloc_prd: got %0d expected 33", alloc_prd); end
    drive(1, 0, 0, 6'd0, 1);
    n_checks++; if (alloc_gnt !== 1'b0) begin n_errors++; $display("FAIL flush_blocks_gnt: got %0b expected 0", alloc_gnt); end
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (free_count !== 7'd31) begin n_errors++; $display("FAIL flush_free_count_hold: got %0d expected 31", free_count); end
    drive(1, 0, 0, 6'd0, 0);
    n_checks++; if (alloc_prd !== 6'd33) begin n_errors++; $display("FAIL flush_realloc0: got %0d expected 33", alloc_prd); end
    tick();
    drive(1, 0, 0, 6'd0, 0);
    n_checks++; if (alloc_prd !== 6'd34) begin n_errors++; $display("FAIL flush_realloc1: got %0d expected 34", alloc_prd); end
    tick();
    // Commit, flush and release together: flush lands after the commit, release still applies.
    drive(0, 1, 1, 6'd7, 1);
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (free_count !== 7'd31) begin n_errors++; $display("FAIL flush_commit_same_cycle_fc: got %0d expected 31", free_count); end
    n_checks++; if (alloc_prd !== 6'd34) begin n_errors++; $display("FAIL flush_commit_same_cycle_prd: got %0d expected 34", alloc_prd); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL flush_err: got %0b expected 0", err); end
  endtask

  task automatic test_zero_and_bad_commit();
    do_reset();
    drive(0, 0, 1, 6'd0, 0);
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (free_count !== 7'd32) begin n_errors++; $display("FAIL zero_release_fc: got %0d expected 32", free_count); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL zero_release_err: got %0b expected 0", err); end
    drive(0, 1, 0, 6'd0, 0);
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL bad_commit_err: got %0b expected 1", err); end
    n_checks++; if (free_count !== 7'd32 || alloc_prd !== 6'd32) begin n_errors++; $display("FAIL bad_commit_ptrs: got fc=%0d prd=%0d expected fc=32 prd=32", free_count, alloc_prd); end
    drive(1, 0, 0, 6'd0, 0);
    n_checks++; if (alloc_gnt !== 1'b1 || alloc_prd !== 6'd32) begin n_errors++; $display("FAIL bad_commit_alloc: got gnt=%0b prd=%0d expected gnt=1 prd=32", alloc_gnt, alloc_prd); end
    tick();
    drive(0, 1, 0, 6'd0, 0);
    tick();
    drive(0, 0, 0, 6'd0, 1);
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (free_count !== 7'd31) begin n_errors++; $display("FAIL bad_commit_later_fc: got %0d expected 31", free_count); end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %0b expected 1", err); end
    do_reset();
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL err_cleared_by_reset: got %0b expected 0", err); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      exp_prd = sb.pop_front();
      drive(1, (i > 0), 1, exp_prd, 0);
      n_checks++; if (alloc_gnt !== 1'b1) begin n_errors++; $display("FAIL wrap_gnt[%0d]: got %0b expected 1", i, alloc_gnt); end
      n_checks++; if (alloc_prd !== exp_prd) begin n_errors++; $display("FAIL wrap_prd[%0d]: got %0d expected %0d", i, alloc_prd, exp_prd); end
      n_checks++; if (free_count !== 7'd32) begin n_errors++; $display("FAIL wrap_fc[%0d]: got %0d expected 32", i, free_count); end
      sb.push_back(exp_prd);
      tick();
    end
    drive(0, 1, 0, 6'd0, 0);
    tick();
    drive(0, 0, 0, 6'd0, 0);
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL wrap_err: got %0b expected 0", err); end
    n_checks++; if (free_count !== 7'd32) begin n_errors++; $display("FAIL wrap_fc_end: got %0d expected 32", free_count); end
    n_checks++; if (alloc_prd !== sb[0]) begin n_errors++; $display("FAIL wrap_next_prd: got %0d expected %0d", alloc_prd, sb[0]); end
  endtask

  task automatic test_full_release();
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      drive(0, 0, 1, 6'(k), 0);
      if (k <= 32) sb.push_back(6'(k));
      tick();
      drive(0, 0, 0, 6'd0, 0);
      if (k == 31) begin
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL full_err_early: got %0b expected 0", err); end
      end
      if (k == 32) begin
        n_checks++; if (free_count !== 7'd64) begin n_errors++; $display("FAIL full_fc_32: got %0d expected 64", free_count); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL full_err_32: got %0b expected 0", err); end
      end
      if (k == 33) begin
        n_checks++; if (free_count !== 7'd64) begin n_errors++; $display("FAIL full_fc_33: got %0d expected 64", free_count); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL full_err_33: got %0b expected 1", err); end
      end
    end
    for (int k = 0; k < 34; k++) begin
      drive(1, 0, 0, 6'd0, 0);
      exp_prd = sb.pop_front();
      n_checks++; if (alloc_gnt !== 1'b1 || alloc_prd !== exp_prd) begin n_errors++; $display("FAIL full_drain[%0d]: got gnt=%0b prd=%0d expected gnt=1 prd=%0d", k, alloc_gnt, alloc_prd, exp_prd); end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    alloc_req = 1'b0;
    commit_valid = 1'b0;
    release_valid = 1'b0;
    release_prd = 6'd0;
    flush = 1'b0;
    test_reset();
    test_alloc_basic();
    test_exhaust_release();
    test_commit_flush();
    test_zero_and_bad_commit();
    test_wrap();
    test_full_release();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
